data_mem_ctrl: RTL and testbench

- Parametrised successor to the single-cycle minisys-32 data memory.
- Adds byte/halfword/word access with sign or zero extension, little-endian lane placement, configurable wait states behind a req/ready handshake, and misalignment detection.
- Sits between the ALU result/Decoder read_data_2 path and the register-file write-back mux.
- Lets the CPU top stall on memory instead of assuming single-cycle access.

---
 rtl/data_mem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data memory controller with byte/halfword/word access and a req/ready handshake.
// Accesses commit after WAIT_STATES extra cycles. Misaligned requests complete with misalign_err.
module data_mem_ctrl #(
   parameter int ADDR_WIDTH  = 14,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        misalign_err
);

   localparam int         DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [2:0] CNT_INIT = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              cnt_q, cnt_d;
   logic                    we_q, sext_q, err_q;
   logic [1:0]              size_q, lane_q;
   logic [ADDR_WIDTH-1:0]   idx_q;
   logic [31:0]             wdata_q;
   logic [1:0]              ld_size_q, ld_lane_q;
   logic                    ld_sext_q, ld_valid_q;

   logic [31:0]             mem [DEPTH];
   logic [31:0]             mem_rd_q;

   logic                    addr_err, commit, use_in;
   logic                    acc_we, acc_sext;
   logic [1:0]              acc_size, acc_lane;
   logic [ADDR_WIDTH-1:0]   acc_idx;
   logic [31:0]             acc_wdata, wlane;
   logic [3:0]              be;
   logic [7:0]              ld_byte;
   logic [15:0]             ld_half;
   logic [31:0]             ld_ext;
   logic                    unused_addr;

   assign unused_addr = ^addr[31:ADDR_WIDTH+2];

   always_comb begin
      addr_err = 1'b0;
      case (size)
         2'b00:   addr_err = 1'b0;
         2'b01:   addr_err = addr[0];
         2'b10:   addr_err = (addr[1:0] != 2'b00);
         default: addr_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (addr_err) begin
                  state_d = DONE;
               end else if (WAIT_STATES == 0) begin
                  state_d = DONE;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               commit  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A zero-wait access commits on its capture edge, so it must use the live inputs.
   assign use_in    = (state_q == IDLE);
   assign acc_we    = use_in ? we                   : we_q;
   assign acc_size  = use_in ? size                 : size_q;
   assign acc_sext  = use_in ? sign_ext             : sext_q;
   assign acc_lane  = use_in ? addr[1:0]            : lane_q;
   assign acc_idx   = use_in ? addr[ADDR_WIDTH+1:2] : idx_q;
   assign acc_wdata = use_in ? wdata                : wdata_q;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         always_comb begin
            be[gi]         = 1'b1;
            wlane[8*gi+:8] = acc_wdata[8*gi+:8];
            case (acc_size)
               2'b00: begin
                  be[gi]         = (acc_lane == 2'(gi));
                  wlane[8*gi+:8] = acc_wdata[7:0];
               end
               2'b01: begin
                  be[gi]         = (acc_lane[1] == 1'(gi / 2));
                  wlane[8*gi+:8] = acc_wdata[8*(gi%2)+:8];
               end
               default: begin
                  be[gi]         = 1'b1;
                  wlane[8*gi+:8] = acc_wdata[8*gi+:8];
               end
            endcase
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (commit && acc_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[acc_idx][8*i+:8] <= wlane[8*i+:8];
         end
      end
      if (commit && !acc_we) mem_rd_q <= mem[acc_idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         sext_q     <= 1'b0;
         err_q      <= 1'b0;
         size_q     <= '0;
         lane_q     <= '0;
         idx_q      <= '0;
         wdata_q    <= '0;
         ld_size_q  <= '0;
         ld_lane_q  <= '0;
         ld_sext_q  <= 1'b0;
         ld_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (use_in && req) begin
            we_q    <= we;
            sext_q  <= sign_ext;
            err_q   <= addr_err;
            size_q  <= size;
            lane_q  <= addr[1:0];
            idx_q   <= addr[ADDR_WIDTH+1:2];
            wdata_q <= wdata;
         end
         // The load result is rebuilt from the raw word using the shape of the last load.
         if (commit && !acc_we) begin
            ld_size_q  <= acc_size;
            ld_lane_q  <= acc_lane;
            ld_sext_q  <= acc_sext;
            ld_valid_q <= 1'b1;
         end
      end
   end

   assign ld_byte = mem_rd_q[8*ld_lane_q+:8];
   assign ld_half = ld_lane_q[1] ? mem_rd_q[31:16] : mem_rd_q[15:0];

   always_comb begin
      ld_ext = mem_rd_q;
      case (ld_size_q)
         2'b00:   ld_ext = {{24{ld_sext_q & ld_byte[7]}}, ld_byte};
         2'b01:   ld_ext = {{16{ld_sext_q & ld_half[15]}}, ld_half};
         default: ld_ext = mem_rd_q;
      endcase
   end

   assign rdata        = ld_valid_q ? ld_ext : 32'd0;
   assign busy         = (state_q != IDLE);
   assign ready        = (state_q == DONE);
   assign misalign_err = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three builds (WAIT_STATES 1, 0 with ADDR_WIDTH 4, and 7)
// exercised with hand-computed loads, stores, misaligned requests and a mid-access reset.
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_s    [3];
   logic        req_s    [3];
   logic        we_s     [3];
   logic [1:0]  size_s   [3];
   logic        sext_s   [3];
   logic [31:0] addr_s   [3];
   logic [31:0] wdata_s  [3];
   logic        busy_s   [3];
   logic        ready_s  [3];
   logic [31:0] rdata_s  [3];
   logic        err_s    [3];

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.ADDR_WIDTH(14), .WAIT_STATES(1)) u_ws1 (
      .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .we(we_s[0]), .size(size_s[0]),
      .sign_ext(sext_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]), .busy(busy_s[0]),
      .ready(ready_s[0]), .rdata(rdata_s[0]), .misalign_err(err_s[0]));

   data_mem_ctrl #(.ADDR_WIDTH(4), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .we(we_s[1]), .size(size_s[1]),
      .sign_ext(sext_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]), .busy(busy_s[1]),
      .ready(ready_s[1]), .rdata(rdata_s[1]), .misalign_err(err_s[1]));

   data_mem_ctrl #(.ADDR_WIDTH(14), .WAIT_STATES(7)) u_ws7 (
      .clk(clk), .rst(rst_s[2]), .req(req_s[2]), .we(we_s[2]), .size(size_s[2]),
      .sign_ext(sext_s[2]), .addr(addr_s[2]), .wdata(wdata_s[2]), .busy(busy_s[2]),
      .ready(ready_s[2]), .rdata(rdata_s[2]), .misalign_err(err_s[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One handshake; inputs are scrambled right after capture to show they are ignored.
   task automatic access(input int d, input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
      @(negedge clk);
      req_s[d] = 1'b1; we_s[d] = w; size_s[d] = sz; sext_s[d] = sx;
      addr_s[d] = a; wdata_s[d] = wd;
      @(posedge clk);
      #1;
      req_s[d] = 1'b0; we_s[d] = ~w; size_s[d] = ~sz; sext_s[d] = ~sx;
      addr_s[d] = ~a; wdata_s[d] = ~wd;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (ready_s[d]) begin
            lat = c;
            break;
         end
      end
      rd = rdata_s[d];
      er = err_s[d];
      $display("txn dut%0d we=%0b size=%0d sx=%0b addr=%h wdata=%h -> lat=%0d rdata=%h err=%0b",
               d, w, sz, sx, a, wd, lat, rd, er);
   endtask

   task automatic txn(input string tag, input int d, input logic w, input logic [1:0] sz,
                      input logic sx, input logic [31:0] a, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_rd, input logic exp_er);
      int          lat;
      logic [31:0] rd;
      logic        er;
      access(d, w, sz, sx, a, wd, lat, rd, er);
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ".rdata"}, rd, exp_rd);
      check({tag, ".err"}, 32'(er), 32'(exp_er));
   endtask

   initial begin
      #1ms;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_s[i] = 1'b1; req_s[i] = 1'b0; we_s[i] = 1'b0; size_s[i] = 2'b00;
         sext_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset%0d.flags", i), 32'({busy_s[i], ready_s[i], err_s[i]}), 32'd0);
         check($sformatf("reset%0d.rdata", i), rdata_s[i], 32'd0);
         rst_s[i] = 1'b0;
      end

      // WAIT_STATES=1: ready two cycles after each request.
      txn("sw_100",    0, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0000_0000, 1'b0);
      txn("lw_100",    0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         2, 32'hDEAD_BEEF, 1'b0);
      txn("sb_102",    0, 1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'hFFFF_FF12, 2, 32'hDEAD_BEEF, 1'b0);
      txn("lw_100b",   0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         2, 32'hDE12_BEEF, 1'b0);
      txn("lb_103",    0, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,         2, 32'hFFFF_FFDE, 1'b0);
      txn("lbu_103",   0, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,         2, 32'h0000_00DE, 1'b0);
      txn("lh_102",    0, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,         2, 32'hFFFF_DE12, 1'b0);
      txn("lhu_100",   0, 1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0,         2, 32'h0000_BEEF, 1'b0);
      txn("lh_101",    0, 1'b0, 2'b01, 1'b1, 32'h0000_0101, 32'h0,         1, 32'h0000_BEEF, 1'b1);
      txn("sw_102",    0, 1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h0000_0000, 1, 32'h0000_BEEF, 1'b1);
      txn("s11_100",   0, 1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h0000_0000, 1, 32'h0000_BEEF, 1'b1);
      txn("lw_100c",   0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         2, 32'hDE12_BEEF, 1'b0);
      txn("sh_100",    0, 1'b1, 2'b01, 1'b0, 32'h0000_0100, 32'h1234_CAFE, 2, 32'hDE12_BEEF, 1'b0);
      txn("lw_sx_100", 0, 1'b0, 2'b10, 1'b1, 32'h0000_0100, 32'h0,         2, 32'hDE12_CAFE, 1'b0);
      txn("lbu_101",   0, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,         2, 32'h0000_00CA, 1'b0);
      txn("sb_100",    0, 1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'h0000_0080, 2, 32'h0000_00CA, 1'b0);
      txn("lb_100",    0, 1'b0, 2'b00, 1'b1, 32'h0000_0100, 32'h0,         2, 32'hFFFF_FF80, 1'b0);

      // WAIT_STATES=0, ADDR_WIDTH=4: single-cycle completion and address wrap.
      txn("w0_sw_40",  1, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hA5A5_A5A5, 1, 32'h0000_0000, 1'b0);
      txn("w0_lw_00",  1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,         1, 32'hA5A5_A5A5, 1'b0);

      // Request held high: the cycle in DONE must not re-accept it.
      @(negedge clk);
      req_s[1] = 1'b1; we_s[1] = 1'b0; size_s[1] = 2'b10; addr_s[1] = 32'h0000_0000;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check($sformatf("held.c%0d.ready", c), 32'(ready_s[1]), 32'(c % 2));
         check($sformatf("held.c%0d.busy", c), 32'(busy_s[1]), 32'(c % 2));
      end
      req_s[1] = 1'b0;
      @(negedge clk);

      // WAIT_STATES=7: ready in cycle 8; reset in WAIT aborts a pending store.
      txn("w7_sw_200", 2, 1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h1234_5678, 8, 32'h0000_0000, 1'b0);
      txn("w7_lw_200", 2, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0,         8, 32'h1234_5678, 1'b0);
      @(negedge clk);
      req_s[2] = 1'b1; we_s[2] = 1'b1; size_s[2] = 2'b10; addr_s[2] = 32'h0000_0200;
      wdata_s[2] = 32'h1111_1111;
      @(posedge clk);
      #1 req_s[2] = 1'b0;
      repeat (2) @(negedge clk);
      check("abort.busy_before", 32'(busy_s[2]), 32'd1);
      #2 rst_s[2] = 1'b1;
      #1;
      check("abort.flags", 32'({busy_s[2], ready_s[2], err_s[2]}), 32'd0);
      check("abort.rdata", rdata_s[2], 32'd0);
      $display("txn dut2 reset pulse during WAIT");
      @(negedge clk);
      rst_s[2] = 1'b0;
      txn("w7_lw_after", 2, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0,       8, 32'h1234_5678, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
